// File: rtl/pc_seq_ctrl_pkg.sv
// Shared fetch-front-end definitions: sequencer states, PC increment,
// default reset address and the J-type index field width.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SLOT  = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          JMP_IDX_W    = 26;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Fetch-control bundle between the PC sequencer (slave) and the
// decode/imem side that drives it (master).
interface pc_seq_ctrl_if;
  import mips_pkg::*;

  logic                  stall;
  logic                  imem_ready;
  logic                  br_valid;
  logic                  br_taken;
  logic                  jmp_valid;
  logic [31:0]           ctl_pc;
  logic signed [31:0]    br_offset;
  logic [JMP_IDX_W-1:0]  jmp_target;
  logic [31:0]           pc_addr;
  logic                  fetch_req;
  logic                  flush;
  logic                  redirect_pending;

  modport master (
    output stall, imem_ready, br_valid, br_taken, jmp_valid,
           ctl_pc, br_offset, jmp_target,
    input  pc_addr, fetch_req, flush, redirect_pending
  );

  modport slave (
    input  stall, imem_ready, br_valid, br_taken, jmp_valid,
           ctl_pc, br_offset, jmp_target,
    output pc_addr, fetch_req, flush, redirect_pending
  );
endinterface

// File: rtl/pc_seq_ctrl_branch_target_calc.sv
// Combinational branch/jump target adder, same arithmetic as add_jump_unit:
// branch = ctl_pc+4+(offset<<2), jump = {ctl_pc+4 [31:28], index, 2'b00}.
module branch_target_calc
  import mips_pkg::*;
(
  input  logic [31:0]          ctl_pc,
  input  logic signed [31:0]   br_offset,
  input  logic [JMP_IDX_W-1:0] jmp_target,
  input  logic                 sel_jmp,
  output logic [31:0]          target
);
  logic [31:0]        pc_plus4;
  logic signed [31:0] off_bytes;

  assign pc_plus4  = ctl_pc + PC_INC;
  assign off_bytes = br_offset <<< 2;
  assign target    = sel_jmp ? {pc_plus4[31:28], jmp_target, 2'b00}
                             : pc_plus4 + $unsigned(off_bytes);
endmodule

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer for the fetch front end. Optional feature macro:
// DELAY_SLOT_EN (one architectural delay slot; otherwise flush-and-retarget).
module pc_seq_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input logic           clk,
  input logic           rst,
  pc_seq_ctrl_if.slave  bus
);
  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target;
  logic        fetch_req, adv, br_hit, redirect, sel_jmp, flush;
`ifdef DELAY_SLOT_EN
  logic [31:0] tgt_q, tgt_d;
`endif

  assign fetch_req = (state_q == FETCH) || (state_q == SLOT);
  assign adv       = fetch_req & bus.imem_ready & ~bus.stall;
  assign br_hit    = bus.br_valid & bus.br_taken;
  assign redirect  = br_hit | bus.jmp_valid;
  // A taken branch outranks a simultaneous jump.
  assign sel_jmp   = bus.jmp_valid & ~br_hit;

  branch_target_calc u_tgt (
    .ctl_pc     (bus.ctl_pc),
    .br_offset  (bus.br_offset),
    .jmp_target (bus.jmp_target),
    .sel_jmp    (sel_jmp),
    .target     (target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
`ifdef DELAY_SLOT_EN
      tgt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef DELAY_SLOT_EN
      tgt_q   <= tgt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
`ifdef DELAY_SLOT_EN
    tgt_d   = tgt_q;
`endif
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
`ifdef DELAY_SLOT_EN
        if (redirect) begin
          // The fetch at pc_addr is the delay slot; retarget once it is accepted.
          if (adv) begin
            pc_d = target;
          end else begin
            tgt_d   = target;
            state_d = SLOT;
          end
        end else if (adv) begin
          pc_d = pc_q + PC_INC;
        end
`else
        if (redirect) begin
          flush = 1'b1;
          pc_d  = target;
        end else if (adv) begin
          pc_d = pc_q + PC_INC;
        end
`endif
      end
`ifdef DELAY_SLOT_EN
      SLOT: begin
        if (adv) begin
          pc_d    = tgt_q;
          state_d = FETCH;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.pc_addr   = pc_q;
  assign bus.fetch_req = fetch_req;
  assign bus.flush     = flush;
`ifdef DELAY_SLOT_EN
  assign bus.redirect_pending = (state_q == SLOT);
`else
  assign bus.redirect_pending = 1'b0;
`endif
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios plus a randomized
// run against a queue-based reference model. Honours DELAY_SLOT_EN.
module tb_pc_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  pc_seq_ctrl_if bus();
  pc_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.stall = 1'b0; bus.imem_ready = 1'b1;
    bus.br_valid = 1'b0; bus.br_taken = 1'b0; bus.jmp_valid = 1'b0;
    bus.ctl_pc = '0; bus.br_offset = '0; bus.jmp_target = '0;
  endtask

  // Leaves the DUT in its first post-reset cycle (fetch not yet requested).
  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  // Reference target from the architectural definition, plain arithmetic.
  function automatic logic [31:0] ref_target(input logic bhit, input logic [31:0] cpc,
                                             input logic [31:0] off, input logic [25:0] jt);
    logic [31:0] nxt;
    nxt = cpc + 32'd4;
    if (bhit) return nxt + off * 32'd4;
    return (nxt & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    cyc();
    n_tests++;
    if (bus.pc_addr !== 32'h0 || bus.fetch_req !== 1'b0 || bus.flush !== 1'b0 ||
        bus.redirect_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: pc=%h req=%b flush=%b pend=%b, want 0/0/0/0",
               bus.pc_addr, bus.fetch_req, bus.flush, bus.redirect_pending);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.fetch_req !== 1'b0 || bus.pc_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_cycle: req=%b pc=%h, want 0 / 0", bus.fetch_req, bus.pc_addr);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_tests++;
      if (bus.fetch_req !== 1'b1 || bus.pc_addr !== 32'(i * 4)) begin
        n_fail++;
        $display("FAIL seq_step%0d: req=%b pc=%h, want 1 / %h", i, bus.fetch_req,
                 bus.pc_addr, 32'(i * 4));
      end
    end
  endtask

  // Reset, then advance until pc_addr reaches 0x14.
  task automatic reach_14();
    do_reset();
    repeat (6) cyc();
    n_tests++;
    if (bus.pc_addr !== 32'h14) begin
      n_fail++;
      $display("FAIL reach_14: pc=%h, want 00000014", bus.pc_addr);
    end
  endtask

  task automatic test_branch(input logic ready);
    reach_14();
    bus.imem_ready = ready;
    bus.br_valid = 1'b1; bus.br_taken = 1'b1;
    bus.ctl_pc = 32'h10; bus.br_offset = 32'sd5;
    #1;
    n_tests++;
    if (bus.flush !== !DS) begin
      n_fail++;
      $display("FAIL br_flush(rdy=%b): flush=%b, want %b", ready, bus.flush, !DS);
    end
    cyc();
    bus.br_valid = 1'b0; bus.br_taken = 1'b0;
    if (DS && !ready) begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (bus.pc_addr !== 32'h14 || bus.redirect_pending !== 1'b1) begin
          n_fail++;
          $display("FAIL br_slot_hold%0d: pc=%h pend=%b, want 00000014 / 1", i,
                   bus.pc_addr, bus.redirect_pending);
        end
        cyc();
      end
      bus.imem_ready = 1'b1;
      cyc();
    end
    n_tests++;
    if (bus.pc_addr !== 32'h28 || bus.redirect_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL br_target(rdy=%b): pc=%h pend=%b, want 00000028 / 0", ready,
               bus.pc_addr, bus.redirect_pending);
    end
  endtask

  task automatic test_jump_and_priority();
    do_reset();
    repeat (3) cyc();
    bus.jmp_valid = 1'b1; bus.ctl_pc = 32'h1000_0020; bus.jmp_target = 26'h40;
    cyc();
    bus.jmp_valid = 1'b0;
    n_tests++;
    if (bus.pc_addr !== 32'h1000_0100) begin
      n_fail++;
      $display("FAIL jump_target: pc=%h, want 10000100", bus.pc_addr);
    end
    cyc();
    bus.jmp_valid = 1'b1; bus.jmp_target = 26'h3_0000; bus.ctl_pc = 32'h0;
    bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_offset = 32'sd1;
    cyc();
    clear_in();
    n_tests++;
    if (bus.pc_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL branch_wins: pc=%h, want 00000008", bus.pc_addr);
    end
    // Not-taken branch is ignored: plain advance.
    bus.br_valid = 1'b1; bus.br_taken = 1'b0; bus.br_offset = 32'sd100;
    #1;
    n_tests++;
    if (bus.flush !== 1'b0) begin
      n_fail++;
      $display("FAIL nt_flush: flush=%b, want 0", bus.flush);
    end
    cyc();
    clear_in();
    n_tests++;
    if (bus.pc_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL not_taken: pc=%h, want 0000000c", bus.pc_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) cyc();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (bus.pc_addr !== 32'h8) begin
        n_fail++;
        $display("FAIL stall_hold%0d: pc=%h, want 00000008", i, bus.pc_addr);
      end
      cyc();
    end
    n_tests++;
    if (bus.pc_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL stall_last: pc=%h, want 00000008", bus.pc_addr);
    end
    bus.stall = 1'b0;
    cyc();
    n_tests++;
    if (bus.pc_addr !== 32'hC) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h, want 0000000c", bus.pc_addr);
    end
  endtask

  task automatic test_wrap_and_neg();
    do_reset();
    cyc();
    bus.jmp_valid = 1'b1; bus.ctl_pc = 32'hF000_0000; bus.jmp_target = 26'h3FF_FFFF;
    cyc();
    bus.jmp_valid = 1'b0;
    n_tests++;
    if (bus.pc_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_setup: pc=%h, want fffffffc", bus.pc_addr);
    end
    cyc();
    n_tests++;
    if (bus.pc_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap: pc=%h, want 00000000", bus.pc_addr);
    end
    bus.br_valid = 1'b1; bus.br_taken = 1'b1;
    bus.ctl_pc = 32'h100; bus.br_offset = 32'hFFFF_FFFF;
    cyc();
    clear_in();
    n_tests++;
    if (bus.pc_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL neg_offset: pc=%h, want 00000100", bus.pc_addr);
    end
  endtask

  task automatic test_rst_mid_slot();
    reach_14();
    bus.imem_ready = 1'b0;
    bus.br_valid = 1'b1; bus.br_taken = 1'b1;
    bus.ctl_pc = 32'h10; bus.br_offset = 32'sd5;
    cyc();
    bus.br_valid = 1'b0;
    n_tests++;
    if (bus.redirect_pending !== DS) begin
      n_fail++;
      $display("FAIL pre_rst_pend: pend=%b, want %b", bus.redirect_pending, DS);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.pc_addr !== 32'h0 || bus.redirect_pending !== 1'b0 || bus.fetch_req !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: pc=%h pend=%b req=%b, want 0/0/0", bus.pc_addr,
               bus.redirect_pending, bus.fetch_req);
    end
    // After reset the stale target must not reappear.
    do_reset();
    repeat (3) cyc();
    n_tests++;
    if (bus.pc_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL post_rst_seq: pc=%h, want 00000008", bus.pc_addr);
    end
  endtask

  task automatic test_random();
    logic        live;
    logic [31:0] mpc, tgt;
    logic [31:0] pend[$];
    logic        last_pulse, bhit, redir, acc, exp_flush;
    int          errs;
    errs = 0;
    do_reset();
    live = 1'b0; mpc = 32'h0; pend = {}; last_pulse = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.stall      = ($urandom_range(0, 3) == 0);
      bus.imem_ready = ($urandom_range(0, 3) != 0);
      bus.br_valid   = !last_pulse && ($urandom_range(0, 4) == 0);
      bus.br_taken   = $urandom_range(0, 1) == 1;
      bus.jmp_valid  = !last_pulse && ($urandom_range(0, 5) == 0);
      bus.ctl_pc     = $urandom;
      bus.br_offset  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63)) - 32'd32;
      bus.jmp_target = 26'($urandom);
      last_pulse     = bus.br_valid | bus.jmp_valid;
      bhit  = bus.br_valid & bus.br_taken;
      redir = bhit | bus.jmp_valid;
      acc   = live & bus.imem_ready & ~bus.stall;
      exp_flush = !DS && live && redir;
      #1;
      n_tests++;
      if (bus.pc_addr !== mpc || bus.fetch_req !== live || bus.flush !== exp_flush ||
          bus.redirect_pending !== (pend.size() != 0)) begin
        n_fail++;
        errs++;
        if (errs <= 8)
          $display("FAIL rand_c%0d: pc=%h req=%b flush=%b pend=%b, want %h/%b/%b/%b", c,
                   bus.pc_addr, bus.fetch_req, bus.flush, bus.redirect_pending,
                   mpc, live, exp_flush, pend.size() != 0);
      end
      tgt = ref_target(bhit, bus.ctl_pc, bus.br_offset, bus.jmp_target);
      if (!live) live = 1'b1;
      else if (pend.size() != 0) begin
        if (acc) mpc = pend.pop_front();
      end else if (redir) begin
        if (!DS || acc) mpc = tgt;
        else pend.push_back(tgt);
      end else if (acc) mpc = mpc + 32'd4;
      cyc();
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump_and_priority();
    test_stall();
    test_wrap_and_neg();
    test_rst_mid_slot();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
